mysystem_pio_out_blink: RTL

Parametrised successor to the system's 16-bit Avalon-MM output PIO used for the HEX display pairs. It adds:
- configurable width and reset value
- atomic bit-set and bit-clear write ports
- a per-bit hardware blink engine with a programmable prescaler

It sits on the Avalon-MM system interconnect as a slave and drives board outputs (HEX segments, LEDs) through out_port.

---
 rtl/mysystem_pio_out_blink.sv | 98 +++++++++
 1 files changed

// File: rtl/mysystem_pio_out_blink.sv
// rtl/mysystem_pio_out_blink.sv - Avalon-MM output PIO with per-bit blink engine; PIO_OUT_BLINK_SETCLR_EN enables OUTSET/OUTCLEAR
module mysystem_pio_out_blink #(
    parameter int unsigned       WIDTH        = 16,
    parameter int unsigned       PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned       RESET_PERIOD = 12499999
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(RESET_PERIOD);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                blink_en_q, blink_en_d;
    logic                phase_q, phase_d;
    logic                wr;
    logic                unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d     = data_q;
        mask_d     = mask_q;
        period_d   = period_q;
        blink_en_d = blink_en_q;
        if (wr) begin
            case (address)
                3'd0: data_d     = writedata[WIDTH-1:0];
                3'd1: mask_d     = writedata[WIDTH-1:0];
                3'd2: period_d   = writedata[PERIOD_W-1:0];
                3'd3: blink_en_d = writedata[0];
`ifdef PIO_OUT_BLINK_SETCLR_EN
                3'd4: data_d     = data_q | writedata[WIDTH-1:0];
                3'd5: data_d     = data_q & ~writedata[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    // Disable (including a clear landing on expiry) beats everything; a PERIOD write restarts the count.
    always_comb begin
        cnt_d   = cnt_q - PERIOD_W'(1);
        phase_d = phase_q;
        if (!blink_en_q || !blink_en_d) begin
            cnt_d   = period_q;
            phase_d = 1'b0;
        end else if (wr && address == 3'd2) begin
            cnt_d = writedata[PERIOD_W-1:0];
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            period_q   <= RST_PERIOD;
            cnt_q      <= RST_PERIOD;
            blink_en_q <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            blink_en_q <= blink_en_d;
            phase_q    <= phase_d;
        end
    end

    assign out_port = data_q & ~(mask_q & {WIDTH{phase_q}});

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata = 32'(data_q);
            3'd1:    readdata = 32'(mask_q);
            3'd2:    readdata = 32'(period_q);
            3'd3:    readdata = {30'd0, phase_q, blink_en_q};
            default: readdata = '0;
        endcase
    end

endmodule
